plot_buffer: RTL

PLOT_BUFFER -- requirements
Module: plot_buffer

---
 rtl/plot_buffer.sv | 113 +++++++++++
 1 files changed

// File: rtl/plot_buffer.sv
// Plot FIFO between the drawing stage and the framebuffer write port.
// In-range plots are queued as {address, colour} and drained whenever the arbiter grants the port.
module plot_buffer #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               vga_x,
  input  logic [6:0]               vga_y,
  input  logic [2:0]               vga_colour,
  input  logic                     vga_plot,
  input  logic                     fb_grant,
  input  logic                     clr_flags,
  output logic [14:0]              fb_addr,
  output logic [2:0]               fb_data,
  output logic                     fb_wren,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     oob
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [8:0]    X_LIM    = 9'(SCREEN_W);
  localparam logic [7:0]    Y_LIM    = 8'(SCREEN_H);
  localparam logic [14:0]   ROW_W    = 15'(SCREEN_W);

  logic [17:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, oob_q, oob_d;
  logic          in_range_s, push_s, pop_s, full_s, empty_s, drop_s, reject_s;
  logic [14:0]   addr_s;

  always_comb begin
    in_range_s = ({1'b0, vga_x} < X_LIM) && ({1'b0, vga_y} < Y_LIM);
    addr_s     = 15'(vga_y) * ROW_W + 15'(vga_x);
    full_s     = (count_q == CNT_FULL);
    empty_s    = (count_q == CNT_ZERO);
    pop_s      = !empty_s && fb_grant;
    push_s     = vga_plot && in_range_s && (!full_s || pop_s);
    drop_s     = vga_plot && in_range_s && full_s && !pop_s;
    reject_s   = vga_plot && !in_range_s;
  end

  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
    // A setting event in the same cycle takes priority over the clear.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_flags) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (reject_s) begin
      oob_d = 1'b1;
    end else if (clr_flags) begin
      oob_d = 1'b0;
    end else begin
      oob_d = oob_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      oob_q    <= oob_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {addr_s, vga_colour};
    end
  end

  // Stale storage is masked while empty so reset drives the write port to zero at once.
  assign fb_wren  = !empty_s;
  assign fb_addr  = empty_s ? 15'd0 : mem_q[rd_ptr_q][17:3];
  assign fb_data  = empty_s ? 3'd0  : mem_q[rd_ptr_q][2:0];
  assign count    = count_q;
  assign full     = full_s;
  assign empty    = empty_s;
  assign overflow = ovf_q;
  assign oob      = oob_q;

endmodule
